// File: rtl/aes_pkg.sv
// Shared constants for the AES command sequencer: engine commands,
// sequencer state encoding and block geometry.
package aes_pkg;

  localparam int BLK_W     = 128;
  localparam int BLK_BYTES = 16;

  localparam logic [1:0] C_ID = 2'b00;
  localparam logic [1:0] C_SP = 2'b01;
  localparam logic [1:0] C_SK = 2'b10;
  localparam logic [1:0] C_ST = 2'b11;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_PT  = 3'd1;
  localparam logic [2:0] S_LOAD_KEY = 3'd2;
  localparam logic [2:0] S_START    = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;

  // Byte 0 is the most significant byte of the block.
  function automatic logic [7:0] blk_byte(
    input logic [BLK_W-1:0] v,
    input logic [3:0]       i
  );
    return v[(BLK_BYTES - 1 - int'(i)) * 8 +: 8];
  endfunction

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin arbiter; one-hot grant, priority passes to the
// other requester whenever a grant is accepted.
module aes_rr_arb2 (
  input  logic       clk,
  input  logic       rst_,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    if (req == 2'b11) gnt = ptr_q ? 2'b10 : 2'b01;
    else              gnt = req;
    ptr_d = ptr_q;
    if (accept) ptr_d = gnt[0];
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/aes_cmd_sequencer.sv
// Shares the byte-serial aes_engine command port between two requesters;
// skips the key load when the engine already holds the requested key.
module aes_cmd_sequencer
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [BLK_W-1:0] req0_pt,
  input  logic [BLK_W-1:0] req1_pt,
  input  logic [BLK_W-1:0] req0_key,
  input  logic [BLK_W-1:0] req1_key,
  output logic [1:0]       rsp_valid,
  output logic             rsp_err,
  output logic             busy,
  output logic             owner,
  output logic [7:0]       eng_din,
  output logic [1:0]       eng_cmd,
  input  logic             eng_ready,
  input  logic             eng_done
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [BLK_W-1:0] pt_q, pt_d;
  logic [BLK_W-1:0] key_q, key_d;
  logic [BLK_W-1:0] kc_q, kc_d;
  logic             kc_vld_q, kc_vld_d;
  logic [1:0]       req_ready_q, req_ready_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic             busy_q, busy_d;
  logic             owner_q, owner_d;
  logic [7:0]       din_q, din_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [1:0]       gnt;
  logic             accept;
  logic [1:0]       rsp_vec;

  assign accept  = (state_q == S_IDLE) & eng_ready & (|req_valid);
  assign rsp_vec = owner_q ? 2'b10 : 2'b01;

  aes_rr_arb2 u_arb (
    .clk    (clk),
    .rst_   (rst_),
    .req    (req_valid),
    .accept (accept),
    .gnt    (gnt)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    pt_d        = pt_q;
    key_d       = key_q;
    kc_d        = kc_q;
    kc_vld_d    = kc_vld_q;
    owner_d     = owner_q;
    req_ready_d = 2'b00;
    rsp_valid_d = 2'b00;
    rsp_err_d   = 1'b0;
    cmd_d       = C_ID;
    din_d       = 8'h00;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          req_ready_d = gnt;
          owner_d     = gnt[1];
          pt_d        = gnt[1] ? req1_pt : req0_pt;
          key_d       = gnt[1] ? req1_key : req0_key;
          cnt_d       = 4'd0;
          state_d     = S_LOAD_PT;
        end
      end
      S_LOAD_PT: begin
        cmd_d = C_SP;
        din_d = blk_byte(pt_q, cnt_q);
        cnt_d = cnt_q + 4'd1;
        tmo_d = '0;
        if (cnt_q == 4'hF) begin
          if (kc_vld_q && (kc_q == key_q)) state_d = S_START;
          else                             state_d = S_LOAD_KEY;
        end
      end
      S_LOAD_KEY: begin
        cmd_d = C_SK;
        din_d = blk_byte(key_q, cnt_q);
        cnt_d = cnt_q + 4'd1;
        tmo_d = '0;
        if (cnt_q == 4'hF) begin
          kc_d     = key_q;
          kc_vld_d = 1'b1;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (eng_done) begin
          rsp_valid_d = rsp_vec;
          state_d     = S_RESP;
        end else if (tmo_q == TMO_MAX) begin
          // Engine state is unknown after an abort; force a key reload.
          rsp_valid_d = rsp_vec;
          rsp_err_d   = 1'b1;
          kc_vld_d    = 1'b0;
          state_d     = S_RESP;
        end else begin
          cmd_d = C_ST;
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      tmo_q       <= '0;
      pt_q        <= '0;
      key_q       <= '0;
      kc_q        <= '0;
      kc_vld_q    <= 1'b0;
      req_ready_q <= 2'b00;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      owner_q     <= 1'b0;
      din_q       <= 8'h00;
      cmd_q       <= C_ID;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      pt_q        <= pt_d;
      key_q       <= key_d;
      kc_q        <= kc_d;
      kc_vld_q    <= kc_vld_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      owner_q     <= owner_d;
      din_q       <= din_d;
      cmd_q       <= cmd_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign eng_din   = din_q;
  assign eng_cmd   = cmd_q;

endmodule

// File: tb/tb_aes_cmd_sequencer.sv
// Directed bench for aes_cmd_sequencer: byte streaming, key caching,
// round-robin, timeout, mid-operation reset and eng_ready gating.
module tb_aes_cmd_sequencer;

  localparam logic [127:0] PT_A  = 128'h00041214120412000C00131108231919;
  localparam logic [127:0] KEY_A = 128'h2475A2B33475568831E2120013AA5487;
  localparam logic [127:0] PT_B  = 128'h3243F6A8885A308D313198A2E0370734;
  localparam logic [127:0] KEY_B = 128'h2B7E151628AED2A6ABF7158809CF4F3C;

  logic         clk = 1'b0;
  logic         rst_;
  logic [1:0]   req_valid, req_valid_t;
  logic [127:0] req0_pt, req1_pt, req0_key, req1_key;
  logic         eng_ready, eng_done;
  logic         done_t;
  logic [1:0]   req_ready, rsp_valid, eng_cmd;
  logic         rsp_err, busy, owner;
  logic [7:0]   eng_din;
  logic [1:0]   req_ready_t, rsp_valid_t, eng_cmd_t;
  logic         rsp_err_t, busy_t, owner_t;
  logic [7:0]   eng_din_t;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  aes_cmd_sequencer dut (
    .clk(clk), .rst_(rst_), .req_valid(req_valid), .req_ready(req_ready),
    .req0_pt(req0_pt), .req1_pt(req1_pt), .req0_key(req0_key), .req1_key(req1_key),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .busy(busy), .owner(owner),
    .eng_din(eng_din), .eng_cmd(eng_cmd), .eng_ready(eng_ready), .eng_done(eng_done)
  );

  aes_cmd_sequencer #(.TIMEOUT_CYCLES(8)) dut_t (
    .clk(clk), .rst_(rst_), .req_valid(req_valid_t), .req_ready(req_ready_t),
    .req0_pt(req0_pt), .req1_pt(req1_pt), .req0_key(req0_key), .req1_key(req1_key),
    .rsp_valid(rsp_valid_t), .rsp_err(rsp_err_t), .busy(busy_t), .owner(owner_t),
    .eng_din(eng_din_t), .eng_cmd(eng_cmd_t), .eng_ready(eng_ready), .eng_done(done_t)
  );

  function automatic logic [7:0] bt(input logic [127:0] v, input int i);
    return v[8*(15-i) +: 8];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input string p);
    chk({p, "_req_ready"}, req_ready, 2'b00);
    chk({p, "_rsp_valid"}, rsp_valid, 2'b00);
    chk({p, "_rsp_err"}, rsp_err, 1'b0);
    chk({p, "_busy"}, busy, 1'b0);
    chk({p, "_owner"}, owner, 1'b0);
    chk({p, "_cmd"}, eng_cmd, 2'b00);
    chk({p, "_din"}, eng_din, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ = 1'b0;
    #1;
    chk_rst("rst");
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  // Starts just before the grant cycle and ends on the IDLE cycle after RESP.
  task automatic run_op(input logic [1:0] g, input logic [127:0] pt,
                        input logic [127:0] key, input bit kload,
                        input int dly, input bit drop, output int waited);
    int n = 0;
    @(negedge clk);
    while (req_ready === 2'b00 && n < 60) begin
      @(negedge clk);
      n++;
    end
    waited = n;
    chk("grant", req_ready, g);
    chk("owner", owner, g[1]);
    chk("busy", busy, 1'b1);
    if (drop) req_valid = 2'b00;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk($sformatf("pt_cmd%0d", k), eng_cmd, 2'b01);
      chk($sformatf("pt_din%0d", k), eng_din, bt(pt, k));
    end
    if (kload) begin
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        chk($sformatf("key_cmd%0d", k), eng_cmd, 2'b10);
        chk($sformatf("key_din%0d", k), eng_din, bt(key, k));
      end
    end
    @(negedge clk);
    chk("start_cmd", eng_cmd, 2'b11);
    chk("start_din", eng_din, 8'h00);
    repeat (dly - 1) @(negedge clk);
    chk("start_hold", eng_cmd, 2'b11);
    chk("no_early_rsp", rsp_valid, 2'b00);
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    chk("rsp_valid", rsp_valid, g);
    chk("rsp_err", rsp_err, 1'b0);
    chk("rsp_cmd", eng_cmd, 2'b00);
    @(negedge clk);
    chk("rsp_pulse", rsp_valid, 2'b00);
    chk("idle_busy", busy, 1'b0);
  endtask

  initial begin
    int w;
    int n;
    rst_ = 1'b0;
    req_valid = 2'b00;
    req_valid_t = 2'b00;
    req0_pt = PT_A;
    req0_key = KEY_A;
    req1_pt = PT_B;
    req1_key = KEY_B;
    eng_ready = 1'b1;
    eng_done = 1'b0;
    done_t = 1'b0;
    #12;
    chk_rst("init");
    @(negedge clk);
    rst_ = 1'b1;

    // Full load, then cached key skips LOAD_KEY.
    req_valid = 2'b01;
    run_op(2'b01, PT_A, KEY_A, 1'b1, 20, 1'b1, w);
    req0_pt = PT_B;
    req_valid = 2'b01;
    run_op(2'b01, PT_B, KEY_A, 1'b0, 20, 1'b1, w);

    // Reset during key byte 5.
    req0_pt = PT_B;
    req0_key = KEY_B;
    req_valid = 2'b01;
    n = 0;
    @(negedge clk);
    while (req_ready === 2'b00 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("mid_grant", req_ready, 2'b01);
    req_valid = 2'b00;
    repeat (22) @(negedge clk);
    chk("mid_cmd", eng_cmd, 2'b10);
    chk("mid_din", eng_din, bt(KEY_B, 5));
    rst_ = 1'b0;
    #1;
    chk_rst("mid");
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("mid_no_rsp", rsp_valid, 2'b00);
      chk("mid_idle", busy, 1'b0);
    end
    req0_pt = PT_A;
    req0_key = KEY_A;
    req_valid = 2'b01;
    run_op(2'b01, PT_A, KEY_A, 1'b1, 4, 1'b1, w);

    // Round-robin with both requesters held valid.
    do_reset();
    req_valid = 2'b11;
    run_op(2'b01, PT_A, KEY_A, 1'b1, 5, 1'b0, w);
    run_op(2'b10, PT_B, KEY_B, 1'b1, 5, 1'b0, w);
    run_op(2'b01, PT_A, KEY_A, 1'b1, 5, 1'b0, w);
    req_valid = 2'b00;

    // eng_ready low defers the grant.
    req0_pt = PT_B;
    eng_ready = 1'b0;
    req_valid = 2'b01;
    repeat (5) begin
      @(negedge clk);
      chk("nrdy_no_grant", req_ready, 2'b00);
      chk("nrdy_idle", busy, 1'b0);
    end
    eng_ready = 1'b1;
    run_op(2'b01, PT_B, KEY_A, 1'b0, 3, 1'b1, w);
    chk("rdy_grant_latency", w, 0);

    // Timeout with TIMEOUT_CYCLES=8.
    req0_pt = PT_A;
    req0_key = KEY_A;
    req_valid_t = 2'b01;
    n = 0;
    @(negedge clk);
    while (req_ready_t === 2'b00 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("to_grant", req_ready_t, 2'b01);
    req_valid_t = 2'b00;
    repeat (17) @(negedge clk);
    chk("to_key_cmd", eng_cmd_t, 2'b10);
    chk("to_key_din", eng_din_t, 8'h24);
    repeat (16) @(negedge clk);
    chk("to_start", eng_cmd_t, 2'b11);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("to_hold%0d", i), eng_cmd_t, 2'b11);
      chk($sformatf("to_norsp%0d", i), rsp_valid_t, 2'b00);
    end
    @(negedge clk);
    chk("to_rsp_valid", rsp_valid_t, 2'b01);
    chk("to_rsp_err", rsp_err_t, 1'b1);
    chk("to_rsp_cmd", eng_cmd_t, 2'b00);
    @(negedge clk);
    chk("to_rsp_pulse", rsp_valid_t, 2'b00);
    req_valid_t = 2'b01;
    n = 0;
    @(negedge clk);
    while (req_ready_t === 2'b00 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("to2_grant", req_ready_t, 2'b01);
    req_valid_t = 2'b00;
    repeat (17) @(negedge clk);
    chk("to2_reload_cmd", eng_cmd_t, 2'b10);
    chk("to2_reload_din", eng_din_t, 8'h24);
    n = 0;
    while (rsp_valid_t === 2'b00 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("to2_rsp_valid", rsp_valid_t, 2'b01);
    chk("to2_rsp_err", rsp_err_t, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
